maxpool_sequencer: RTL and testbench

//  Streaming max-reduction controller for pooling layers. Accepts a valid/ready stream of
//  N-bit sign-magnitude fixed-point values (Q fraction bits) and reduces each window of WIN

---
 rtl/maxpool_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_maxpool_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/maxpool_sequencer.sv
// Streaming max-pool window reducer for sign-magnitude samples, valid/ready on both sides.
// Optional argmax output (out_idx) is enabled by defining MAXPOOL_ARGMAX_EN.
module maxpool_sequencer #(
  parameter int N = 32,
  parameter int Q = 16,
  parameter int WIN = 4,
  localparam int IDX_W = $clog2(WIN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
`ifdef MAXPOOL_ARGMAX_EN
  output logic [IDX_W-1:0] out_idx,
  output logic             busy
`else
  output logic             busy
`endif
);

  if (WIN < 2 || WIN > 256 || Q < 0 || Q >= N) begin : g_param_check
    $error("maxpool_sequencer: illegal WIN/Q parameterisation");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [N-1:0]     acc_r;
  logic [N-1:0]     out_data_r;
  logic [IDX_W-1:0] cnt_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             in_ready_s;
  logic             start_s;
  logic             step_s;
  logic             close_s;
  logic             win_s;
  logic [N-1:0]     max_s;

  // Strict sign-magnitude "greater than"; both zeros compare equal so ties keep the incumbent.
  function automatic logic sm_gt(input logic [N-1:0] a, input logic [N-1:0] b);
    logic a_neg;
    logic b_neg;
    logic r;
    a_neg = a[N-1] && (a[N-2:0] != {(N-1){1'b0}});
    b_neg = b[N-1] && (b[N-2:0] != {(N-1){1'b0}});
    if (!a_neg && b_neg) begin
      r = 1'b1;
    end else if (a_neg && !b_neg) begin
      r = 1'b0;
    end else if (!a_neg) begin
      r = a[N-2:0] > b[N-2:0];
    end else begin
      r = a[N-2:0] < b[N-2:0];
    end
    return r;
  endfunction

  assign win_s = sm_gt(in_data, acc_r);
  assign max_s = win_s ? in_data : acc_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state, input-side ready and window start/close decode.
  always_comb begin
    next_state_s = state_r;
    in_ready_s   = 1'b0;
    start_s      = 1'b0;
    step_s       = 1'b0;
    close_s      = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          start_s      = 1'b1;
          next_state_s = in_last ? HOLD : ACCUM;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          step_s = 1'b1;
          if (in_last || (cnt_r == IDX_W'(WIN - 1))) begin
            close_s      = 1'b1;
            next_state_s = HOLD;
          end else begin
            next_state_s = ACCUM;
          end
        end else begin
          next_state_s = ACCUM;
        end
      end
      HOLD: begin
        // A retiring result frees the slot, so a new window may open in the same cycle.
        in_ready_s = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            start_s      = 1'b1;
            next_state_s = in_last ? HOLD : ACCUM;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Accumulator, sample counter and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r       <= {N{1'b0}};
      cnt_r       <= {IDX_W{1'b0}};
      out_data_r  <= {N{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (start_s) begin
        acc_r <= in_data;
        cnt_r <= IDX_W'(1);
        if (in_last) begin
          out_data_r <= in_data;
        end else begin
          out_data_r <= out_data_r;
        end
      end else if (step_s) begin
        acc_r <= max_s;
        if (close_s) begin
          cnt_r      <= {IDX_W{1'b0}};
          out_data_r <= max_s;
        end else begin
          cnt_r      <= cnt_r + IDX_W'(1);
          out_data_r <= out_data_r;
        end
      end else begin
        acc_r      <= acc_r;
        cnt_r      <= cnt_r;
        out_data_r <= out_data_r;
      end
      out_valid_r <= (next_state_s == HOLD);
      busy_r      <= (next_state_s == ACCUM);
    end
  end

`ifdef MAXPOOL_ARGMAX_EN
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] out_idx_r;
  logic [IDX_W-1:0] idx_next_s;

  // cnt_r is the 0-based position of the sample being accepted in ACCUM.
  assign idx_next_s = win_s ? cnt_r : idx_r;

  // Argmax tracking; position only moves when a sample strictly wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r     <= {IDX_W{1'b0}};
      out_idx_r <= {IDX_W{1'b0}};
    end else if (start_s) begin
      idx_r <= {IDX_W{1'b0}};
      if (in_last) begin
        out_idx_r <= {IDX_W{1'b0}};
      end else begin
        out_idx_r <= out_idx_r;
      end
    end else if (step_s) begin
      idx_r <= idx_next_s;
      if (close_s) begin
        out_idx_r <= idx_next_s;
      end else begin
        out_idx_r <= out_idx_r;
      end
    end else begin
      idx_r     <= idx_r;
      out_idx_r <= out_idx_r;
    end
  end

  assign out_idx = out_idx_r;
`endif

  assign in_ready  = rst_n & in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_maxpool_sequencer.sv
// Randomised + directed bench for maxpool_sequencer against a queue-based window model.
// Build with or without MAXPOOL_ARGMAX_EN; argmax checks follow the same macro.
module tb_maxpool_sequencer;
  localparam int N = 32;
  localparam int WIN = 4;
  localparam int IDX_W = $clog2(WIN);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_data;
  logic             busy;
`ifdef MAXPOOL_ARGMAX_EN
  logic [IDX_W-1:0] out_idx;
`endif

  maxpool_sequencer #(.N(N), .Q(16), .WIN(WIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef MAXPOOL_ARGMAX_EN
    .out_idx(out_idx),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0] win_q[$];
  logic [N-1:0] exp_d[$];
  int           exp_i[$];

  logic [N-1:0] obs_data;
  logic         obs_valid;
  logic         obs_in_ready;
  int           obs_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic longint sm_value(input logic [N-1:0] x);
    longint mag;
    mag = longint'(x[N-2:0]);
    return x[N-1] ? -mag : mag;
  endfunction

  // Close the modelled window: first sample holding the largest numeric value wins.
  task automatic close_window();
    longint best;
    int     bi;
    best = sm_value(win_q[0]);
    bi = 0;
    for (int i = 1; i < win_q.size(); i++) begin
      if (sm_value(win_q[i]) > best) begin
        best = sm_value(win_q[i]);
        bi = i;
      end
    end
    exp_d.push_back(win_q[bi]);
    exp_i.push_back(bi);
    win_q.delete();
  endtask

  // One clock: drive inputs, check every output against the model, then update the model.
  task automatic step(input logic iv, input logic [N-1:0] d, input logic lst, input logic ordy);
    bit pending;
    @(negedge clk);
    in_valid = iv; in_data = d; in_last = lst; out_ready = ordy;
    #1;
    pending = (exp_d.size() != 0);
    chk("out_valid", out_valid, pending);
    chk("busy", busy, win_q.size() != 0);
    chk("in_ready", in_ready, !pending || ordy);
    if (pending) begin
      chk("out_data", out_data, exp_d[0]);
`ifdef MAXPOOL_ARGMAX_EN
      chk("out_idx", out_idx, exp_i[0]);
`endif
    end
    obs_data = out_data;
    obs_valid = out_valid;
    obs_in_ready = in_ready;
`ifdef MAXPOOL_ARGMAX_EN
    obs_idx = out_idx;
`else
    obs_idx = 0;
`endif
    if (pending && out_valid && ordy) begin
      exp_d.pop_front();
      exp_i.pop_front();
    end
    if (iv && in_ready) begin
      win_q.push_back(d);
      if (lst || win_q.size() == WIN) close_window();
    end
  endtask

  task automatic do_reset(input logic iv);
    @(negedge clk);
    rst_n = 1'b0; in_valid = iv; in_data = $urandom; in_last = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    win_q.delete(); exp_d.delete(); exp_i.delete();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 32'h0000_0000);
    chk("rst_in_ready_after", in_ready, 1'b1);
`ifdef MAXPOOL_ARGMAX_EN
    chk("rst_out_idx", out_idx, 32'd0);
`endif
  endtask

  task automatic send4(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] c, input logic [N-1:0] e);
    step(1'b1, a, 1'b0, 1'b1);
    step(1'b1, b, 1'b0, 1'b1);
    step(1'b1, c, 1'b0, 1'b1);
    step(1'b1, e, 1'b0, 1'b1);
  endtask

  task automatic expect_result(input string tag, input logic [N-1:0] d, input int idx);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk({tag, "_valid"}, obs_valid, 1'b1);
    chk({tag, "_data"}, obs_data, d);
`ifdef MAXPOOL_ARGMAX_EN
    chk({tag, "_idx"}, obs_idx, idx);
`endif
  endtask

  initial begin
    logic [N-1:0] rd;
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    send4(32'h0001_0000, 32'h0003_0000, 32'h0002_0000, 32'h0000_8000);
    expect_result("t1", 32'h0003_0000, 1);

    send4(32'h8001_0000, 32'h8003_0000, 32'h8000_8000, 32'h8002_0000);
    expect_result("t2", 32'h8000_8000, 2);

    send4(32'h8000_0000, 32'h0000_0000, 32'h8005_0000, 32'h8001_0000);
    expect_result("t3", 32'h8000_0000, 0);

    step(1'b1, 32'h0002_0000, 1'b0, 1'b1);
    step(1'b1, 32'h0007_0000, 1'b1, 1'b1);
    expect_result("t4_early", 32'h0007_0000, 1);
    send4(32'h0001_0000, 32'h0002_0000, 32'h0009_0000, 32'h0003_0000);
    expect_result("t4_full", 32'h0009_0000, 2);

    send4(32'h0004_0000, 32'h0001_0000, 32'h0006_0000, 32'h0002_0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h0011_0000, 1'b0, 1'b0);
      chk("t5_stall_ready", obs_in_ready, 1'b0);
      chk("t5_stall_data", obs_data, 32'h0006_0000);
    end
    step(1'b1, 32'h0011_0000, 1'b0, 1'b1);
    chk("t5_retire_accept", obs_in_ready, 1'b1);
    step(1'b1, 32'h0012_0000, 1'b0, 1'b1);
    step(1'b1, 32'h0010_0000, 1'b0, 1'b1);
    step(1'b1, 32'h0013_0000, 1'b0, 1'b1);
    expect_result("t5_next", 32'h0013_0000, 3);

    step(1'b1, 32'h7FFF_0000, 1'b0, 1'b1);
    step(1'b1, 32'h0005_0000, 1'b0, 1'b1);
    do_reset(1'b1);
    send4(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    expect_result("t6", 32'h0001_0000, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        rd[N-1] = 1'($urandom_range(0, 1));
        rd[N-2:0] = ($urandom_range(0, 3) == 0) ? 31'($urandom_range(0, 2)) : 31'($urandom);
        step($urandom_range(0, 3) != 0, rd, $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
      end
    end
    repeat (WIN + 2) step(1'b0, 32'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
